// File: rtl/controller_state_sequencer.sv
// Multicycle CPU controller sequencer: steps each instruction through
// FETCH/DECODE/LOAD/EXECUTE/MEMWAIT/WRITEBACK, arbitrates exceptions and
// interrupts, applies a memory-wait timeout and counts retired instructions.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   enable            global stall (low = every register holds)
//   memReady          memory transaction complete this cycle
//   illegalOp         decoder: undefined opcode (used in DECODE)
//   needsLoad         decoder: instruction goes through LOAD
//   needsMem          decoder: instruction accesses data memory
//   isHalt            decoder: HALT instruction (used in WRITEBACK)
//   faultRaise        datapath fault in LOAD/EXECUTE/MEMWAIT
//   interruptRequest  level interrupt line
//   interruptEnable   status-register interrupt enable
//   state             current controller state
//   exceptionPending  exception latched, not yet taken
//   interruptPending  interrupt latched, not yet taken
//   exceptionCause    0 none, 1 illegal, 2 fault, 3 bus timeout
//   retiredCount      instructions completed since reset

package controllerPkg;
    typedef enum logic [3:0] {
        RESET0,
        RESET1,
        FETCH,
        DECODE,
        LOAD,
        EXECUTE,
        MEMWAIT,
        WRITEBACK,
        EXCEPTION,
        INTERRUPT,
        HALT
    } states;
endpackage

module controller_state_sequencer
    import controllerPkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        memReady,
    input  logic        illegalOp,
    input  logic        needsLoad,
    input  logic        needsMem,
    input  logic        isHalt,
    input  logic        faultRaise,
    input  logic        interruptRequest,
    input  logic        interruptEnable,
    output states       state,
    output logic        exceptionPending,
    output logic        interruptPending,
    output logic [1:0]  exceptionCause,
    output logic [31:0] retiredCount
);

    localparam int unsigned WAIT_W = 16;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_FAULT   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    states             state_nxt;
    logic              exc_nxt;
    logic              int_nxt;
    logic [1:0]        cause_nxt;
    logic [31:0]       retired_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              int_req_c;
    logic              timeout_c;

    assign int_req_c = interruptRequest & interruptEnable;
    // memReady on the last allowed cycle still completes the access
    assign timeout_c = (wait_cnt == WAIT_LAST) && !memReady;

    // State and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= RESET0;
            exceptionPending <= 1'b0;
            interruptPending <= 1'b0;
            exceptionCause   <= 2'd0;
            retiredCount     <= 32'd0;
            wait_cnt         <= '0;
        end else if (enable) begin
            state            <= state_nxt;
            exceptionPending <= exc_nxt;
            interruptPending <= int_nxt;
            exceptionCause   <= cause_nxt;
            retiredCount     <= retired_nxt;
            wait_cnt         <= wait_nxt;
        end
    end

    // Next-state, exception/interrupt latching, retire and wait counters
    always_comb begin
        state_nxt   = state;
        exc_nxt     = exceptionPending;
        int_nxt     = interruptPending;
        cause_nxt   = exceptionCause;
        retired_nxt = retiredCount;
        wait_nxt    = wait_cnt;

        unique case (state)
            RESET0: state_nxt = RESET1;
            RESET1: state_nxt = FETCH;
            FETCH: begin
                if (memReady) begin
                    state_nxt = DECODE;
                end else if (timeout_c) begin
                    state_nxt = EXCEPTION;
                    exc_nxt   = 1'b1;
                    if (!exceptionPending) cause_nxt = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                if (illegalOp) begin
                    state_nxt = EXCEPTION;
                    exc_nxt   = 1'b1;
                    if (!exceptionPending) cause_nxt = CAUSE_ILLEGAL;
                end else if (needsLoad) begin
                    state_nxt = LOAD;
                end else begin
                    state_nxt = EXECUTE;
                end
            end
            LOAD: begin
                state_nxt = needsMem ? MEMWAIT : WRITEBACK;
                if (faultRaise) begin
                    exc_nxt = 1'b1;
                    if (!exceptionPending) cause_nxt = CAUSE_FAULT;
                end
            end
            EXECUTE: begin
                state_nxt = WRITEBACK;
                if (faultRaise) begin
                    exc_nxt = 1'b1;
                    if (!exceptionPending) cause_nxt = CAUSE_FAULT;
                end
            end
            MEMWAIT: begin
                if (memReady) begin
                    state_nxt = WRITEBACK;
                end else if (timeout_c) begin
                    state_nxt = EXCEPTION;
                end
                // a timeout outranks a fault raised on the same cycle
                if (timeout_c) begin
                    exc_nxt = 1'b1;
                    if (!exceptionPending) cause_nxt = CAUSE_TIMEOUT;
                end else if (faultRaise) begin
                    exc_nxt = 1'b1;
                    if (!exceptionPending) cause_nxt = CAUSE_FAULT;
                end
            end
            WRITEBACK: begin
                retired_nxt = retiredCount + 32'd1;
                if (exceptionPending)      state_nxt = EXCEPTION;
                else if (interruptPending) state_nxt = INTERRUPT;
                else if (isHalt)           state_nxt = HALT;
                else                       state_nxt = FETCH;
            end
            EXCEPTION: begin
                exc_nxt   = 1'b0;
                state_nxt = FETCH;
            end
            INTERRUPT: begin
                int_nxt   = 1'b0;
                state_nxt = FETCH;
            end
            HALT: begin
                if (int_req_c) state_nxt = INTERRUPT;
            end
            default: state_nxt = RESET0;
        endcase

        // interrupts latch everywhere except while being taken
        if (int_req_c && (state != INTERRUPT)) int_nxt = 1'b1;

        if (state_nxt != state) begin
            wait_nxt = '0;
        end else if (((state == FETCH) || (state == MEMWAIT)) && !memReady) begin
            wait_nxt = wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_controller_state_sequencer.sv
// Directed testbench for controller_state_sequencer. A second instance with
// WAIT_LIMIT=4 shares the stimulus to exercise the bus-timeout path.

module tb_controller_state_sequencer;
    import controllerPkg::*;

    logic clk = 1'b0;
    logic reset, enable, memReady, illegalOp, needsLoad, needsMem, isHalt;
    logic faultRaise, interruptRequest, interruptEnable;

    states       state, state2;
    logic        exc_p, exc_p2, int_p, int_p2;
    logic [1:0]  cause, cause2;
    logic [31:0] retired, retired2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    controller_state_sequencer #(.WAIT_LIMIT(255)) dut (
        .clk(clk), .reset(reset), .enable(enable), .memReady(memReady),
        .illegalOp(illegalOp), .needsLoad(needsLoad), .needsMem(needsMem),
        .isHalt(isHalt), .faultRaise(faultRaise),
        .interruptRequest(interruptRequest), .interruptEnable(interruptEnable),
        .state(state), .exceptionPending(exc_p), .interruptPending(int_p),
        .exceptionCause(cause), .retiredCount(retired)
    );

    controller_state_sequencer #(.WAIT_LIMIT(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .memReady(memReady),
        .illegalOp(illegalOp), .needsLoad(needsLoad), .needsMem(needsMem),
        .isHalt(isHalt), .faultRaise(faultRaise),
        .interruptRequest(interruptRequest), .interruptEnable(interruptEnable),
        .state(state2), .exceptionPending(exc_p2), .interruptPending(int_p2),
        .exceptionCause(cause2), .retiredCount(retired2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chks(input string tag, input states exp);
        chk(tag, 32'(state), 32'(exp));
    endtask

    task automatic chks2(input string tag, input states exp);
        chk(tag, 32'(state2), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; memReady = 1'b1; illegalOp = 1'b0;
        needsLoad = 1'b0; needsMem = 1'b0; isHalt = 1'b0; faultRaise = 1'b0;
        interruptRequest = 1'b0; interruptEnable = 1'b0;

        // reset values
        #12;
        chks("rst_state", RESET0);
        chk("rst_exc", 32'(exc_p), 32'd0);
        chk("rst_int", 32'(int_p), 32'd0);
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_retired", retired, 32'd0);
        tick();
        reset = 1'b0;
        chks("rst_hold", RESET0);
        tick(); chks("reset1", RESET1);
        tick(); chks("fetch0", FETCH);

        // ALU stream
        for (int i = 1; i <= 3; i++) begin
            tick(); chks("alu_decode", DECODE);
            tick(); chks("alu_execute", EXECUTE);
            tick(); chks("alu_writeback", WRITEBACK);
            tick(); chks("alu_fetch", FETCH);
            chk("alu_retired", retired, 32'(i));
        end

        // load with 4 memReady-low cycles in MEMWAIT; limit-4 copy times out
        needsLoad = 1'b1; needsMem = 1'b1;
        tick(); chks("ld_decode", DECODE);
        tick(); chks("ld_load", LOAD);
        memReady = 1'b0;
        tick(); chks("ld_memwait", MEMWAIT);
        for (int i = 0; i < 3; i++) begin
            tick(); chks("ld_wait", MEMWAIT); chks2("ld_wait4", MEMWAIT);
        end
        tick();
        chks("ld_wait_last", MEMWAIT);
        chks2("to_state", EXCEPTION);
        chk("to_exc", 32'(exc_p2), 32'd1);
        chk("to_cause", 32'(cause2), 32'd3);
        chk("to_retired", retired2, 32'd3);
        memReady = 1'b1;
        tick(); chks("ld_writeback", WRITEBACK);
        tick(); chks("ld_fetch", FETCH);
        chk("ld_retired", retired, 32'd4);

        // register-indirect branch: LOAD straight to WRITEBACK
        needsMem = 1'b0;
        tick(); chks("br_decode", DECODE);
        tick(); chks("br_load", LOAD);
        tick(); chks("br_writeback", WRITEBACK);
        tick(); chks("br_fetch", FETCH);
        chk("br_retired", retired, 32'd5);
        needsLoad = 1'b0;

        // illegal opcode
        illegalOp = 1'b1;
        tick(); chks("ill_decode", DECODE);
        tick(); chks("ill_exc", EXCEPTION);
        chk("ill_pending", 32'(exc_p), 32'd1);
        chk("ill_cause", 32'(cause), 32'd1);
        chk("ill_retired", retired, 32'd5);
        illegalOp = 1'b0;
        tick(); chks("ill_fetch", FETCH);
        chk("ill_clear", 32'(exc_p), 32'd0);
        chk("ill_cause_hold", 32'(cause), 32'd1);

        // fault in EXECUTE, taken after WRITEBACK
        tick(); chks("flt_decode", DECODE);
        tick(); chks("flt_execute", EXECUTE);
        faultRaise = 1'b1;
        tick(); chks("flt_writeback", WRITEBACK);
        chk("flt_pending", 32'(exc_p), 32'd1);
        chk("flt_cause", 32'(cause), 32'd2);
        faultRaise = 1'b0;
        tick(); chks("flt_exc", EXCEPTION);
        chk("flt_retired", retired, 32'd6);
        tick(); chks("flt_fetch", FETCH);
        chk("flt_clear", 32'(exc_p), 32'd0);

        // one-cycle interrupt pulse during EXECUTE
        interruptEnable = 1'b1;
        tick(); tick(); chks("irq_execute", EXECUTE);
        interruptRequest = 1'b1;
        tick(); chks("irq_writeback", WRITEBACK);
        chk("irq_pending", 32'(int_p), 32'd1);
        interruptRequest = 1'b0;
        tick(); chks("irq_taken", INTERRUPT);
        chk("irq_held", 32'(int_p), 32'd1);
        chk("irq_retired", retired, 32'd7);
        tick(); chks("irq_fetch", FETCH);
        chk("irq_clear", 32'(int_p), 32'd0);

        // fault and interrupt together: exception first
        tick(); tick(); chks("both_execute", EXECUTE);
        faultRaise = 1'b1; interruptRequest = 1'b1;
        tick(); chks("both_writeback", WRITEBACK);
        faultRaise = 1'b0; interruptRequest = 1'b0;
        tick(); chks("both_exc", EXCEPTION);
        chk("both_int_held", 32'(int_p), 32'd1);
        tick(); chks("both_fetch", FETCH);
        tick(); tick(); tick(); chks("both_writeback2", WRITEBACK);
        tick(); chks("both_int", INTERRUPT);
        chk("both_retired", retired, 32'd9);
        tick(); chks("both_fetch2", FETCH);

        // HALT, request masked, then unmasked
        isHalt = 1'b1;
        tick(); tick(); tick(); chks("halt_writeback", WRITEBACK);
        tick(); chks("halt_enter", HALT);
        isHalt = 1'b0;
        interruptEnable = 1'b0; interruptRequest = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(); chks("halt_hold", HALT);
        end
        chk("halt_no_int", 32'(int_p), 32'd0);
        interruptEnable = 1'b1;
        tick(); chks("halt_wake", INTERRUPT);
        chk("halt_int_pending", 32'(int_p), 32'd1);
        interruptRequest = 1'b0; interruptEnable = 1'b0;
        tick(); chks("halt_fetch", FETCH);
        chk("halt_retired", retired, 32'd10);

        // resync both instances, then stall mid-MEMWAIT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick(); chks("rs_fetch", FETCH); chks2("rs_fetch4", FETCH);
        needsLoad = 1'b1; needsMem = 1'b1;
        tick(); tick(); chks("st_load", LOAD);
        memReady = 1'b0;
        tick(); tick(); tick(); chks("st_memwait", MEMWAIT); chks2("st_memwait4", MEMWAIT);
        enable = 1'b0;
        memReady = 1'b1; faultRaise = 1'b1;
        interruptRequest = 1'b1; interruptEnable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chks("st_frozen", MEMWAIT); chks2("st_frozen4", MEMWAIT);
        end
        chk("st_int_ignored", 32'(int_p), 32'd0);
        chk("st_exc_ignored", 32'(exc_p), 32'd0);
        chk("st_retired", retired, 32'd0);
        memReady = 1'b0; faultRaise = 1'b0;
        interruptRequest = 1'b0; interruptEnable = 1'b0;
        enable = 1'b1;
        tick(); chks2("st_resume4", MEMWAIT);
        tick(); chks2("st_timeout4", EXCEPTION); chks("st_still_wait", MEMWAIT);
        memReady = 1'b1;
        tick(); chks("st_writeback", WRITEBACK);
        tick(); chks("st_fetch", FETCH);
        chk("st_retired2", retired, 32'd1);

        // asynchronous reset in LOAD
        tick(); tick(); chks("ar_load", LOAD);
        #2 reset = 1'b1;
        #1;
        chks("ar_state", RESET0);
        chk("ar_exc", 32'(exc_p), 32'd0);
        chk("ar_int", 32'(int_p), 32'd0);
        chk("ar_cause", 32'(cause), 32'd0);
        chk("ar_retired", retired, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controller_state_sequencer.md
# controller_state_sequencer

Multicycle CPU controller sequencer that produces the registered `state` word for every per-state output-logic block, including address, ALU and register-file control. It walks each instruction through FETCH/DECODE/LOAD/EXECUTE/MEMWAIT/WRITEBACK. It also arbitrates exceptions and interrupts, enforces a memory-wait timeout and counts retired instructions. It sits between the instruction decoder and the per-state output-logic blocks in the controller.

## Interface
- WAIT_LIMIT, 255: max cycles spent in FETCH or MEMWAIT without `memReady` before a bus-timeout exception (1..65535).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  global stall; low = every register holds.
- memReady  in  1  memory transaction complete this cycle.
- illegalOp  in  1  decoder: current opcode undefined (sampled in DECODE).
- needsLoad  in  1  decoder: instruction uses LOAD state (loads, stores, register-indirect branches).
- needsMem  in  1  decoder: instruction performs a data-memory access (loads, stores).
- isHalt  in  1  decoder: HALT instruction.
- faultRaise  in  1  datapath fault (alignment, divide) in LOAD/EXECUTE/MEMWAIT.
- interruptRequest  in  1  level interrupt line.
- interruptEnable  in  1  status-register interrupt enable.
- state  out  controllerPkg::states  current state.
- exceptionPending  out  1  exception latched, not yet taken.
- interruptPending  out  1  interrupt latched, not yet taken.
- exceptionCause  out  2  0 none, 1 illegal, 2 fault, 3 bus timeout.
- retiredCount  out  32  instructions completed since reset.

## Operation
- States: RESET0, RESET1, FETCH, DECODE, LOAD, EXECUTE, MEMWAIT, WRITEBACK, EXCEPTION, INTERRUPT, HALT.
- RESET0 -> RESET1 -> FETCH unconditionally.
- FETCH: `memReady` -> DECODE. Timeout -> EXCEPTION with cause 3.
- DECODE: `illegalOp` -> EXCEPTION with cause 1. Else `needsLoad` -> LOAD. Else EXECUTE.
- LOAD: `needsMem` -> MEMWAIT. Else -> WRITEBACK (register-indirect branch).
- EXECUTE -> WRITEBACK.
- MEMWAIT: `memReady` -> WRITEBACK. Timeout -> EXCEPTION with cause 3.
- WRITEBACK: retiredCount += 1 (wraps 0xFFFFFFFF -> 0). Next state by priority:
  - exceptionPending -> EXCEPTION.
  - interruptPending -> INTERRUPT.
  - isHalt -> HALT.
  - else FETCH.
- EXCEPTION: clears exceptionPending, cause holds its value until the next exception. -> FETCH.
- INTERRUPT: clears interruptPending. -> FETCH.
- HALT: holds until interruptRequest & interruptEnable, then -> INTERRUPT.
- faultRaise in LOAD/EXECUTE/MEMWAIT sets exceptionPending with cause 2. Execution continues to WRITEBACK; the exception is taken there.
- Illegal opcode and timeout go to EXCEPTION directly. exceptionPending is set for one cycle (visible in the EXCEPTION state) and is not counted as retired.
- interruptPending is set when interruptRequest & interruptEnable is high in any state except INTERRUPT. Once set, it stays set until INTERRUPT, even if the request drops.
- Exception beats interrupt when both are pending. A second fault while an exception is pending does not change the cause; the first cause wins.
- Wait counter (16 bit):
  - clears on every state change;
  - increments each enabled cycle in FETCH/MEMWAIT without memReady;
  - timeout = counter == WAIT_LIMIT-1 and memReady low. memReady on that same cycle wins.

## Timing
- All outputs registered, updated on the clk edge only when enable=1.
- Reset values: state=RESET0, exceptionPending=0, interruptPending=0, exceptionCause=0, retiredCount=0, wait counter=0.
- Reset asserted mid-instruction returns to RESET0 immediately (async). No partial retire.
- Minimum instruction latency with memReady always high:
  - ALU instruction: FETCH, DECODE, EXECUTE, WRITEBACK = 4 cycles.
  - Load/store: FETCH, DECODE, LOAD, MEMWAIT, WRITEBACK = 5 cycles.
  - Register-indirect branch: FETCH, DECODE, LOAD, WRITEBACK = 4 cycles.
- Each cycle of memReady low in FETCH/MEMWAIT adds exactly one cycle.
- enable low freezes state, counters and pending flags. Inputs are ignored except interruptRequest, which is also ignored while stalled.
- Decoder inputs are sampled only in the states that consume them. Outside those states they are don't-care.

## Test plan
- Reset, memReady=1, ALU stream (needsLoad=0): RESET0, RESET1, FETCH, DECODE, EXECUTE, WRITEBACK, FETCH… retiredCount=3 after 3 WRITEBACKs.
- Load with memReady low 4 cycles in MEMWAIT: MEMWAIT lasts 5 cycles, then WRITEBACK. With WAIT_LIMIT=4, same stimulus -> EXCEPTION, cause=3, retiredCount unchanged.
- illegalOp in DECODE -> next state EXCEPTION, cause=1, then FETCH. Same instruction with faultRaise in EXECUTE -> WRITEBACK, EXCEPTION, cause=2.
- interruptRequest pulse of 1 cycle during EXECUTE with interruptEnable=1 -> interruptPending held, WRITEBACK -> INTERRUPT -> FETCH. Fault and interrupt together -> EXCEPTION first, INTERRUPT after next WRITEBACK.
- isHalt -> HALT held 20 cycles. interruptEnable=0 with request -> remains HALT. Set enable -> INTERRUPT next cycle.
- enable low 3 cycles mid-MEMWAIT -> state, wait counter and retiredCount frozen. Reset asserted in LOAD -> state=RESET0 asynchronously, all outputs zero.
